param_ram: RTL
==============

PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 6, address width; depth DEPTH = 2**ADDR_W.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 Reset  input  1  asynchronous active-high reset.
REQ-006 clear  input  1  synchronous request to start a zero-fill sweep.
REQ-007 writeEnable  input  1  write strobe.
REQ-008 writeAddress  input  ADDR_W  write location.
REQ-009 writeData  input  DATA_W  write word.
REQ-010 readEn  input  1  read request.
REQ-011 readAddress  input  ADDR_W  read location.
REQ-012 ReadData  output  DATA_W  registered read word.
REQ-013 readValid  output  1  one-cycle pulse marking new ReadData.
REQ-014 busy  output  1  high while a zero-fill sweep runs.

Function
REQ-015 FSM SHALL have exactly two states, IDLE and CLEAR, with a pointer clr_ptr of ADDR_W bits.
REQ-016 In CLEAR, each cycle SHALL write 0 to Memory[clr_ptr] and increment clr_ptr; when clr_ptr == DEPTH-1 the next state SHALL be IDLE, so one sweep takes exactly DEPTH cycles.
REQ-017 busy SHALL be 1 exactly while state == CLEAR.
REQ-018 In IDLE, clear = 1 SHALL enter CLEAR with clr_ptr = 0 on the next edge, and any write in that cycle SHALL be dropped.
REQ-019 clear = 1 during CLEAR SHALL restart the sweep at clr_ptr = 0.
REQ-020 While busy, writeEnable and readEn SHALL be ignored: no write, readValid = 0, ReadData held.
REQ-021 In IDLE, writeEnable = 1 SHALL store writeData at writeAddress on the edge.
REQ-022 In IDLE, readEn = 1 SHALL give ReadData = Memory[readAddress] and readValid = 1 after the next edge (1-cycle latency).
REQ-023 Without readEn, readValid SHALL be 0 and ReadData SHALL hold its last value; it is never tri-stated.
REQ-024 Read and write in the same cycle to different addresses SHALL both complete.
REQ-025 Read and write in the same cycle to the same address SHALL follow REQ-031.

Reset
REQ-026 Reset = 1 SHALL immediately force state = CLEAR, clr_ptr = 0, ReadData = 0, readValid = 0, busy = 1.
REQ-027 On Reset release, a full DEPTH-cycle sweep SHALL run; memory content is defined as all-zero only once busy falls.
REQ-028 Reset asserted mid-sweep or mid-access SHALL abort the operation and apply REQ-026.

Configuration
REQ-029 Macro RAM_BYPASS_EN SHALL select same-address read-during-write behaviour.
REQ-030 With RAM_BYPASS_EN defined, ReadData SHALL return the writeData being written (new data).
REQ-031 Without RAM_BYPASS_EN, ReadData SHALL return the pre-write content (old data); the write still completes.

Structure
REQ-032 Package ram_pkg SHALL hold the state enumeration (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-033 The sweep FSM and pointer SHALL be sub-module ram_clear_fsm, which outputs busy, clr_ptr and a clear-write strobe; the storage array and read path stay in param_ram.

Verification
REQ-034 Reset pulse, then release -> busy = 1 for exactly 64 cycles; reading every address afterwards returns 0x00 with readValid pulses.
REQ-035 Write 0xA5 to addr 5, then read addr 5 -> ReadData = 0xA5 and readValid = 1 one cycle after the readEn cycle.
REQ-036 Same-cycle write 0x3C and read at addr 9, which holds 0x11 -> ReadData = 0x3C with RAM_BYPASS_EN, 0x11 without; a later read of addr 9 returns 0x3C in both builds.
REQ-037 clear pulse in IDLE plus a same-cycle write to addr 2 -> the write is dropped, busy stays high for 64 cycles, and all addresses read 0x00.
REQ-038 Write and read attempts during busy -> readValid stays 0; after the sweep, the target address reads 0x00.
REQ-039 Reset asserted at sweep cycle 20 -> outputs reset immediately; after release, a full 64-cycle sweep restarts from addr 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and sweep-state encoding for the zero-fill RAM.
// Default geometry used by param_ram when no parameters are overridden.
package ram_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 6;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } ramState_t;

endpackage

// File: rtl/ram_clear_fsm.sv
// Zero-fill sweep controller: walks clrPtr over every address once per sweep
// and raises busy/clrWrite for exactly DEPTH cycles; clear restarts the sweep.
module ram_clear_fsm
   import ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              clear,
   output logic              busy,
   output logic              clrWrite,
   output logic [ADDR_W-1:0] clrPtr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   ramState_t state;

   // Reset parks the controller at the start of a sweep so release begins a full fill.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state    <= CLEAR;
         clrPtr   <= '0;
         busy     <= 1'b1;
         clrWrite <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  state    <= CLEAR;
                  clrPtr   <= '0;
                  busy     <= 1'b1;
                  clrWrite <= 1'b1;
               end
            end
            CLEAR: begin
               if (clear) begin
                  clrPtr <= '0;
               end else if (clrPtr == LAST_ADDR) begin
                  state    <= IDLE;
                  clrPtr   <= '0;
                  busy     <= 1'b0;
                  clrWrite <= 1'b0;
               end else begin
                  clrPtr <= clrPtr + 1'b1;
               end
            end
            default: begin
               state    <= CLEAR;
               clrPtr   <= '0;
               busy     <= 1'b1;
               clrWrite <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/param_ram.sv
// Parameterized single-clock RAM with registered read and a zero-fill sweep.
// Define RAM_BYPASS_EN to return new data on same-address read-during-write.
module param_ram
   import ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              clear,
   input  logic              writeEnable,
   input  logic [ADDR_W-1:0] writeAddress,
   input  logic [DATA_W-1:0] writeData,
   input  logic              readEn,
   input  logic [ADDR_W-1:0] readAddress,
   output logic [DATA_W-1:0] ReadData,
   output logic              readValid,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clrWrite;
   logic [ADDR_W-1:0] clrPtr;
   logic              wrAccept;
   logic              rdAccept;
   logic [DATA_W-1:0] rdWord;

   ram_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) clearFsm (
      .clk      (clk),
      .Reset    (Reset),
      .clear    (clear),
      .busy     (busy),
      .clrWrite (clrWrite),
      .clrPtr   (clrPtr)
   );

   // A clear request in IDLE wins over a same-cycle write.
   assign wrAccept = writeEnable & ~busy & ~clear;
   assign rdAccept = readEn & ~busy;

`ifdef RAM_BYPASS_EN
   assign rdWord = (wrAccept && (writeAddress == readAddress)) ? writeData : mem[readAddress];
`else
   assign rdWord = mem[readAddress];
`endif

   always_ff @(posedge clk) begin
      if (clrWrite) begin
         mem[clrPtr] <= '0;
      end else if (wrAccept) begin
         mem[writeAddress] <= writeData;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         ReadData  <= '0;
         readValid <= 1'b0;
      end else begin
         readValid <= rdAccept;
         if (rdAccept) begin
            ReadData <= rdWord;
         end
      end
   end

endmodule
